pompa_paliwa: RTL and testbench
===============================

POMPA_PALIWA -- requirements
Module: pompa_paliwa

Interface
REQ-001 The block SHALL have parameter OKRES, default 4: clock cycles per delivered litre; legal range 2..255.
REQ-002 The block SHALL have parameter ROZRUCH, default 2: pump spin-up cycles before the first litre; legal range 1..255.
REQ-003 The block SHALL have parameter POJEMNOSC, default 200: full level of each tank in litres; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port clockEn, input, 1 bit: pump enable from the dispenser.
REQ-007 The block SHALL have port paliwo, input, 2 bits, selecting fuel: 01 LPG, 10 benzyna, 11 diesel, 00 none.
REQ-008 The block SHALL have port uzupelnij, input, 1 bit: synchronous refill request.
REQ-009 The block SHALL have port clk_pompa, output, 1 bit: registered one-cycle pulse per delivered litre.
REQ-010 The block SHALL have port pusty, output, 1 bit: high while in state PUSTY.
REQ-011 The block SHALL have port poziom, output, 8 bits: current level of the tank selected by the live paliwo input, and 0 when paliwo=00.
REQ-012 The block SHALL have port wydano, output, 8 bits: litres delivered in the current session.
REQ-013 The block SHALL have port stan, output, 2 bits: state code.

Function
REQ-014 The block SHALL keep three 8-bit tank levels (LPG, benzyna, diesel) and a latched fuel code.
REQ-015 The FSM SHALL have four states, STOJ=00, ROZRUCH=01, POMPUJ=10 and PUSTY=11, and stan SHALL equal the current state code.
REQ-016 In STOJ, when clockEn=1 and paliwo!=00 are sampled, the block SHALL latch paliwo, clear wydano, and move to PUSTY if the selected level is 0, otherwise to ROZRUCH.
REQ-017 In STOJ, when clockEn=1 and paliwo=00 are sampled, the block SHALL remain in STOJ.
REQ-018 ROZRUCH SHALL last exactly ROZRUCH cycles and then enter POMPUJ with the litre divider at 0.
REQ-019 In POMPUJ, the divider SHALL count 0..OKRES-1 and wrap; at each wrap the block SHALL assert clk_pompa for the next cycle, decrement the latched tank level, and increment wydano, saturating at 255.
REQ-020 The first clk_pompa pulse SHALL be high exactly ROZRUCH+OKRES cycles after the edge that sampled clockEn=1, and later pulses SHALL be OKRES cycles apart.
REQ-021 When a decrement brings the level to 0, the block SHALL enter PUSTY on the same edge that raises clk_pompa.
REQ-022 In ROZRUCH or POMPUJ, clockEn=0 SHALL return the block to STOJ on the next edge; any partial litre SHALL be discarded and wydano SHALL be held.
REQ-023 Changes on paliwo after latching SHALL be ignored until the block returns to STOJ; poziom SHALL still follow the live paliwo input.
REQ-024 In PUSTY, pusty SHALL be 1, no pulses SHALL be produced, and clockEn=0 SHALL return the block to STOJ.
REQ-025 uzupelnij=1 SHALL set all three tanks to POJEMNOSC in any state, without changing the state.
REQ-026 If a refill and a litre decrement fall on the same edge, the refill SHALL win: level becomes POJEMNOSC, while the pulse and wydano++ still occur.
REQ-027 clk_pompa SHALL be 0 in every cycle other than the single post-wrap cycle.

Reset
REQ-028 While reset=1, asynchronously: state SHALL be STOJ, all tanks SHALL be POJEMNOSC, the latched fuel SHALL be 00, the divider and spin-up counters SHALL be 0, clk_pompa=0, pusty=0, wydano=0 and stan=00.
REQ-029 Reset asserted mid-pumping SHALL abort the session immediately, with no further pulse.

Verification
REQ-030 Defaults, paliwo=11, clockEn=1 for 30 cycles SHALL give the first clk_pompa 6 cycles after the enable edge, pulses every 4 cycles, wydano=6, and diesel poziom=194.
REQ-031 With the LPG level preloaded to 2 by pumping, a new LPG session SHALL give 2 pulses, then stan=11 and pusty=1; clockEn=0 SHALL then give stan=00 and pusty=0.
REQ-032 Benzyna with clockEn dropped 2 cycles after the 3rd pulse SHALL give stan=00 the next cycle, wydano=3 held, and no 4th pulse.
REQ-033 uzupelnij asserted in PUSTY SHALL set all tanks to 200 with stan still 11; stan SHALL become 00 only after clockEn=0.
REQ-034 reset asserted between pulses while in POMPUJ SHALL drive stan=00, wydano=0 and all tanks to 200 at once, with no glitch on clk_pompa.
REQ-035 clockEn=1 with paliwo=00 for 10 cycles SHALL keep stan=00 with no pulses, and poziom=0.

Source files
------------

// File: rtl/pompa_paliwa.sv
// Fuel pump controller: three tanks, spin-up delay, one clk_pompa pulse per litre,
// per-session litre counter and an empty-tank state.
module pompa_paliwa #(
    parameter int OKRES     = 4,
    parameter int ROZRUCH   = 2,
    parameter int POJEMNOSC = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clockEn,
    input  logic [1:0] paliwo,
    input  logic       uzupelnij,
    output logic       clk_pompa,
    output logic       pusty,
    output logic [7:0] poziom,
    output logic [7:0] wydano,
    output logic [1:0] stan
);

    typedef enum logic [1:0] {
        ST_STOJ    = 2'b00,
        ST_ROZRUCH = 2'b01,
        ST_POMPUJ  = 2'b10,
        ST_PUSTY   = 2'b11
    } stan_t;

    localparam logic [7:0] PELNY     = 8'(POJEMNOSC);
    localparam logic [7:0] DZIEL_MAX = 8'(OKRES - 1);
    localparam logic [7:0] ROZR_MAX  = 8'(ROZRUCH - 1);

    stan_t      stan_q, stan_d;
    logic [1:0] paliwo_q;
    logic [7:0] lpg, benzyna, diesel;
    logic [7:0] dzielnik, rozruch_cnt;
    logic [7:0] poziom_q;
    logic       start, wrap, rozruch_done;

    always_comb begin
        case (paliwo)
            2'b01:   poziom = lpg;
            2'b10:   poziom = benzyna;
            2'b11:   poziom = diesel;
            default: poziom = 8'd0;
        endcase
    end

    always_comb begin
        case (paliwo_q)
            2'b01:   poziom_q = lpg;
            2'b10:   poziom_q = benzyna;
            2'b11:   poziom_q = diesel;
            default: poziom_q = 8'd0;
        endcase
    end

    assign start        = (stan_q == ST_STOJ) && clockEn && (paliwo != 2'b00);
    assign rozruch_done = (rozruch_cnt == ROZR_MAX);
    assign wrap         = (stan_q == ST_POMPUJ) && clockEn && (dzielnik == DZIEL_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stan_q <= ST_STOJ;
        else       stan_q <= stan_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns stan_d and no latch is inferred.
        stan_d = stan_q;
        case (stan_q)
            ST_STOJ:
                if (start) stan_d = (poziom == 8'd0) ? ST_PUSTY : ST_ROZRUCH;
            ST_ROZRUCH:
                if (!clockEn)          stan_d = ST_STOJ;
                else if (rozruch_done) stan_d = ST_POMPUJ;
            ST_POMPUJ:
                if (!clockEn) stan_d = ST_STOJ;
                // A refill on the emptying edge keeps the tank full, so no PUSTY then.
                else if (wrap && poziom_q == 8'd1 && !uzupelnij) stan_d = ST_PUSTY;
            ST_PUSTY:
                if (!clockEn) stan_d = ST_STOJ;
            default: stan_d = ST_STOJ;
        endcase
    end

    always_comb begin
        stan  = stan_q;
        pusty = (stan_q == ST_PUSTY);
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: tank levels are plain registers, so they take the full level on reset.
        if (reset) begin
            clk_pompa   <= 1'b0;
            paliwo_q    <= 2'b00;
            wydano      <= 8'd0;
            dzielnik    <= 8'd0;
            rozruch_cnt <= 8'd0;
            lpg         <= PELNY;
            benzyna     <= PELNY;
            diesel      <= PELNY;
        end else begin
            clk_pompa   <= wrap;
            rozruch_cnt <= (stan_q == ST_ROZRUCH && clockEn && !rozruch_done) ? rozruch_cnt + 8'd1 : 8'd0;
            dzielnik    <= (stan_q == ST_POMPUJ && clockEn && !wrap) ? dzielnik + 8'd1 : 8'd0;
            if (start) begin
                paliwo_q <= paliwo;
                wydano   <= 8'd0;
            end else if (wrap && wydano != 8'd255) begin
                wydano <= wydano + 8'd1;
            end
            if (uzupelnij) begin
                lpg     <= PELNY;
                benzyna <= PELNY;
                diesel  <= PELNY;
            end else if (wrap) begin
                case (paliwo_q)
                    2'b01:   lpg     <= lpg - 8'd1;
                    2'b10:   benzyna <= benzyna - 8'd1;
                    2'b11:   diesel  <= diesel - 8'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pompa_paliwa.sv
// Directed bench for pompa_paliwa with default parameters; expected values are hand-computed.
module tb_pompa_paliwa;

    logic       clk = 1'b0;
    logic       reset, clockEn, uzupelnij;
    logic [1:0] paliwo;
    logic       clk_pompa, pusty;
    logic [7:0] poziom, wydano;
    logic [1:0] stan;

    int n_cmp = 0;
    int n_bad = 0;

    pompa_paliwa dut (
        .clk(clk), .reset(reset), .clockEn(clockEn), .paliwo(paliwo), .uzupelnij(uzupelnij),
        .clk_pompa(clk_pompa), .pusty(pusty), .poziom(poziom), .wydano(wydano), .stan(stan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge where outputs are sampled.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // clockEn=1 sampled on edges 0..n_on-1 (edge 0 is the enable edge), 0 on edge n_on.
    task automatic pump(input logic [1:0] f, input int n_on,
                        output int pulses, output int first, output int last);
        paliwo  = f;
        clockEn = 1'b1;
        pulses  = 0;
        first   = -1;
        last    = -1;
        for (int i = 0; i <= n_on; i++) begin
            cycle();
            if (clk_pompa) begin
                pulses++;
                if (first < 0) first = i;
                last = i;
            end
            if (i == n_on - 1) clockEn = 1'b0;
        end
    endtask

    task automatic idle_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (clk_pompa) pulses++;
        end
    endtask

    int p, first, last;

    initial begin
        reset = 1'b1; clockEn = 1'b0; uzupelnij = 1'b0; paliwo = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_stan", stan, 0);
        check("rst_pusty", pusty, 0);
        check("rst_wydano", wydano, 0);
        check("rst_pulse", clk_pompa, 0);
        check("rst_poziom_none", poziom, 0);
        paliwo = 2'b01; #1 check("rst_lpg", poziom, 200);
        paliwo = 2'b10; #1 check("rst_ben", poziom, 200);
        paliwo = 2'b11; #1 check("rst_die", poziom, 200);
        reset = 1'b0;
        @(negedge clk);

        // No fuel selected: enable is ignored.
        paliwo = 2'b00; clockEn = 1'b1; p = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (clk_pompa || stan != 2'b00) p++;
        end
        check("none_activity", p, 0);
        check("none_poziom", poziom, 0);
        clockEn = 1'b0;
        cycle();

        // Diesel, 30 enabled cycles.
        pump(2'b11, 30, p, first, last);
        check("die_pulses", p, 6);
        check("die_first", first, 6);
        check("die_last", last, 26);
        check("die_wydano", wydano, 6);
        check("die_poziom", poziom, 194);
        check("die_stan_stop", stan, 0);

        // Benzyna, enable dropped two cycles after the third pulse.
        pump(2'b10, 16, p, first, last);
        check("ben_pulses", p, 3);
        check("ben_last", last, 14);
        check("ben_stan_stop", stan, 0);
        idle_pulses(6, p);
        check("ben_no_4th", p, 0);
        check("ben_wydano_held", wydano, 3);
        check("ben_poziom", poziom, 197);

        // Drain LPG to 2 litres, then empty it.
        pump(2'b01, 795, p, first, last);
        check("lpg_pre_pulses", p, 198);
        check("lpg_pre_poziom", poziom, 2);
        paliwo = 2'b01; clockEn = 1'b1; p = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (clk_pompa) p++;
        end
        check("lpg_pulses", p, 2);
        check("lpg_stan_empty", stan, 3);
        check("lpg_pusty", pusty, 1);
        check("lpg_poziom0", poziom, 0);
        check("lpg_wydano", wydano, 2);
        idle_pulses(4, p);
        check("lpg_empty_no_pulse", p, 0);
        clockEn = 1'b0;
        cycle();
        check("lpg_stan_stop", stan, 0);
        check("lpg_pusty_clr", pusty, 0);

        // Start on an empty tank goes straight to PUSTY; refill there keeps the state.
        clockEn = 1'b1;
        cycle();
        check("empty_start_stan", stan, 3);
        check("empty_start_wydano", wydano, 0);
        uzupelnij = 1'b1;
        cycle();
        uzupelnij = 1'b0;
        check("refill_stan", stan, 3);
        check("refill_lpg", poziom, 200);
        paliwo = 2'b10; #1 check("refill_ben", poziom, 200);
        paliwo = 2'b11; #1 check("refill_die", poziom, 200);
        cycle();
        check("refill_stan_held", stan, 3);
        clockEn = 1'b0;
        cycle();
        check("refill_stan_stop", stan, 0);

        // Refill on the decrement edge wins; latched fuel ignores live paliwo changes.
        paliwo = 2'b11; clockEn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i == 5) uzupelnij = 1'b1;
        end
        cycle();
        uzupelnij = 1'b0;
        check("clash_pulse", clk_pompa, 1);
        check("clash_poziom", poziom, 200);
        check("clash_wydano", wydano, 1);
        paliwo = 2'b10;
        repeat (4) cycle();
        check("latch_pulse2", clk_pompa, 1);
        check("latch_ben", poziom, 200);
        paliwo = 2'b11; #1 check("latch_die", poziom, 199);
        check("latch_wydano", wydano, 2);

        // Reset between pulses.
        repeat (2) cycle();
        check("mid_no_pulse", clk_pompa, 0);
        check("mid_stan", stan, 2);
        reset = 1'b1;
        #1;
        check("arst_stan", stan, 0);
        check("arst_wydano", wydano, 0);
        check("arst_die", poziom, 200);
        check("arst_pulse", clk_pompa, 0);
        p = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (clk_pompa) p++;
        end
        check("arst_hold_no_pulse", p, 0);
        clockEn = 1'b0;
        reset = 1'b0;
        idle_pulses(6, p);
        check("arst_after_no_pulse", p, 0);
        check("arst_after_stan", stan, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
